mod_reg16_4to16: RTL and testbench

//  Word-to-block assembler for the AES256 datapath. Sits directly downstream of the 1-to-4 byte register.

---
 rtl/aes_pkg.sv | 12 +
 rtl/mod_word_slot.sv | 22 ++
 rtl/mod_reg16_4to16.sv | 91 +++++++++
 tb/tb_mod_reg16_4to16.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types and sizes for the word-to-block assembler.
package aes_pkg;

  localparam int unsigned AES_NW = 4;
  localparam int unsigned AES_NB = 4;

  typedef logic [3:0][7:0]  word_t;
  typedef logic [15:0][7:0] state_t;

  typedef enum logic {FILL, FULL} asm_state_e;

endpackage

// File: rtl/mod_word_slot.sv
// One NB-byte column register of the assembled AES state, with load enable and async clear.
module mod_word_slot
  import aes_pkg::*;
#(
  parameter int unsigned NB = AES_NB
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [NB-1:0][7:0] d,
  output logic [NB-1:0][7:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mod_reg16_4to16.sv
// Collects NW 32-bit AES columns into a 128-bit state and holds it until consumed.
// Optional sticky overflow flag on dropped writes: define MOD_REG16_OVF_EN.
module mod_reg16_4to16
  import aes_pkg::*;
#(
  parameter int unsigned NW = AES_NW,
  parameter int unsigned NB = AES_NB
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr_en,
  input  logic [NB-1:0][7:0]        i,
  input  logic                      rd_en,
  output logic [NW*NB-1:0][7:0]     o,
  output logic                      reg_full,
  output logic [$clog2(NW+1)-1:0]   count
`ifdef MOD_REG16_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int unsigned CW = $clog2(NW + 1);
  localparam int unsigned PW = (NW > 1) ? $clog2(NW) : 1;

  asm_state_e    state;
  logic [PW-1:0] wr_ptr;
  logic [NW-1:0] slot_ld;

  // A release cycle (FULL with rd_en) also accepts a write into slot 0.
  for (genvar k = 0; k < NW; k++) begin : g_slot
    assign slot_ld[k] = wr_en & (wr_ptr == PW'(k)) & ((state == FILL) | rd_en);

    mod_word_slot #(
      .NB(NB)
    ) u_slot (
      .clk(clk),
      .clr(resetn),
      .ld (slot_ld[k]),
      .d  (i),
      .q  (o[NB*k +: NB])
    );
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state    <= FILL;
      wr_ptr   <= '0;
      count    <= '0;
      reg_full <= 1'b0;
`ifdef MOD_REG16_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      unique case (state)
        FILL: begin
          if (wr_en) begin
            if (wr_ptr == PW'(NW - 1)) begin
              state    <= FULL;
              reg_full <= 1'b1;
              wr_ptr   <= '0;
              count    <= CW'(NW);
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
              count  <= count + CW'(1);
            end
          end
        end
        FULL: begin
          if (rd_en) begin
            state    <= FILL;
            reg_full <= 1'b0;
            if (wr_en) begin
              wr_ptr <= PW'(1);
              count  <= CW'(1);
            end else begin
              wr_ptr <= '0;
              count  <= '0;
            end
          end else if (wr_en) begin
`ifdef MOD_REG16_OVF_EN
            ovf <= 1'b1;
`endif
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reg16_4to16.sv
// Directed and randomized bench for mod_reg16_4to16 against a byte-array block model.
module tb_mod_reg16_4to16;
  import aes_pkg::*;

  logic             clk;
  logic             resetn;
  logic             wr_en;
  logic [3:0][7:0]  i;
  logic             rd_en;
  logic [15:0][7:0] o;
  logic             reg_full;
  logic [2:0]       count;
`ifdef MOD_REG16_OVF_EN
  logic             ovf;
`endif

  mod_reg16_4to16 dut (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .i       (i),
    .rd_en   (rd_en),
    .o       (o),
    .reg_full(reg_full),
    .count   (count)
`ifdef MOD_REG16_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: 16 stored bytes, number of words held, full flag, sticky overflow.
  byte unsigned m_mem [16];
  int           m_cnt;
  bit           m_full;
  bit           m_ovf;

  localparam logic [127:0] SEQ_BLOCK = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [31:0]  SEQ_W0    = 32'h03020100;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_block();
    logic [127:0] v = '0;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = m_mem[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_mem[k] = 8'h00;
    m_cnt  = 0;
    m_full = 0;
    m_ovf  = 0;
  endtask

  task automatic model_store(input int slot, input logic [31:0] w);
    for (int k = 0; k < 4; k++) m_mem[4*slot + k] = w[8*k +: 8];
  endtask

  task automatic model_step(input bit w, input bit r, input logic [31:0] d);
    if (!m_full) begin
      if (w) begin
        model_store(m_cnt, d);
        m_cnt++;
        if (m_cnt == 4) m_full = 1;
      end
    end else if (r) begin
      m_full = 0;
      m_cnt  = 0;
      if (w) begin
        model_store(0, d);
        m_cnt = 1;
      end
    end else if (w) begin
      m_ovf = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".o"}, o, model_block());
    check({tag, ".full"}, {127'd0, reg_full}, {127'd0, m_full});
    check({tag, ".count"}, {125'd0, count}, 128'(m_cnt));
`ifdef MOD_REG16_OVF_EN
    check({tag, ".ovf"}, {127'd0, ovf}, {127'd0, m_ovf});
`endif
  endtask

  // Called just after a falling edge: drive, clock once, check on the next falling edge.
  task automatic cycle(input string tag, input bit w, input bit r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    i     = d;
    model_step(w, r, d);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] w;
    resetn = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    i      = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    resetn = 1'b0;
    @(negedge clk);

    // Back-to-back fill.
    for (int k = 0; k < 4; k++) begin
      w = SEQ_W0 + 32'h04040404 * k;
      cycle("fill", 1'b1, 1'b0, w);
    end
    check("t1.o", o, SEQ_BLOCK);
    check("t1.full", {127'd0, reg_full}, 128'd1);
    check("t1.count", {125'd0, count}, 128'd4);
    cycle("release", 1'b0, 1'b1, '0);

    // Fill with idle gaps; count must hold during gaps.
    for (int k = 0; k < 4; k++) begin
      w = SEQ_W0 + 32'h04040404 * k;
      cycle("gapfill", 1'b1, 1'b0, w);
      check("t2.count", {125'd0, count}, 128'(k + 1));
      repeat (2 + (k % 2)) begin
        cycle("gap", 1'b0, 1'b0, 32'hffffffff);
        check("t2.hold", {125'd0, count}, 128'(k + 1));
      end
    end
    check("t2.o", o, SEQ_BLOCK);

    // Dropped write while full.
    cycle("drop", 1'b1, 1'b0, 32'hdeadbeef);
    check("t3.o", o, SEQ_BLOCK);
    check("t3.count", {125'd0, count}, 128'd4);

    // Release and capture in the same cycle.
    cycle("relwr", 1'b1, 1'b1, 32'h13121110);
    check("t4.o", o, {SEQ_BLOCK[127:32], 32'h13121110});
    check("t4.full", {127'd0, reg_full}, 128'd0);
    check("t4.count", {125'd0, count}, 128'd1);

    // Read request during fill is ignored.
    cycle("fill2", 1'b1, 1'b0, 32'h17161514);
    cycle("rdfill", 1'b0, 1'b1, 32'h0);
    check("t5.count", {125'd0, count}, 128'd2);
    check("t5.full", {127'd0, reg_full}, 128'd0);

    // Asynchronous reset mid-cycle.
    #2 resetn = 1'b1;
    #1;
    model_reset();
    check("t6.o", o, 128'd0);
    check("t6.count", {125'd0, count}, 128'd0);
    check("t6.full", {127'd0, reg_full}, 128'd0);
    @(negedge clk);
    check_all("t6.held");
    resetn = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      w = SEQ_W0 + 32'h04040404 * k;
      cycle("refill", 1'b1, 1'b0, w);
    end
    check("t6.o2", o, SEQ_BLOCK);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle("rand", ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
